// File: rtl/osd_defs.sv
// Shared definitions for the video-to-AXI-Stream bridge: FSM encoding,
// FIFO entry layout and counter sizing helpers.
package osd_defs;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    IN_FRAME   = 2'd1,
    DROP_FRAME = 2'd2
  } state_t;

  // FIFO entry is {sof, eol, pixel}; the pixel occupies the low bits.
  localparam int ENTRY_FLAG_BITS = 2;

  function automatic int eol_bit(input int data_width);
    return data_width;
  endfunction

  function automatic int sof_bit(input int data_width);
    return data_width + 1;
  endfunction

  function automatic int pix_cnt_width(input int frame_w);
    return $clog2(frame_w) + 1;
  endfunction

  function automatic int line_cnt_width(input int frame_h);
    return $clog2(frame_h) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read; a write into a full FIFO
// is accepted only when a read retires the head on the same edge.
module sync_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  always_comb begin
    do_rd    = rd_en && (count_q != '0);
    do_wr    = wr_en && ((count_q != COUNT_FULL) || do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count/pointers alone define which slots are live.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == COUNT_FULL);
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/video_axis_bridge.sv
// Converts fval/lval/dval pixel timing into an AXI-Stream video master with
// tuser on the first pixel of a frame, tlast at line end, and sticky errors.
module video_axis_bridge
  import osd_defs::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int FRAME_W    = 640,
  parameter int FRAME_H    = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  pix_clk,
  input  logic                  rstb,
  input  logic                  fval,
  input  logic                  lval,
  input  logic                  dval,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tuser,
  output logic                  m_tlast,
  output logic                  overflow,
  output logic                  size_err,
  input  logic                  clr_err
);

  localparam int EW      = DATA_WIDTH + ENTRY_FLAG_BITS;
  localparam int PW      = pix_cnt_width(FRAME_W);
  localparam int LW      = line_cnt_width(FRAME_H);
  localparam int EOL_BIT = eol_bit(DATA_WIDTH);
  localparam int SOF_BIT = sof_bit(DATA_WIDTH);
  localparam logic [PW-1:0] PIX_LAST  = PW'(FRAME_W - 1);
  localparam logic [PW-1:0] PIX_FULL  = PW'(FRAME_W);
  localparam logic [LW-1:0] LINE_FULL = LW'(FRAME_H);

  state_t         state_q, state_d;
  logic           fval_q, lval_q;
  logic [PW-1:0]  pix_cnt_q, pix_cnt_d;
  logic [LW-1:0]  line_cnt_q, line_cnt_d, lines_done;
  logic           sof_pend_q, sof_pend_d;
  logic           stg_valid_q, stg_valid_d;
  logic [EW-1:0]  stg_entry_q, stg_entry_d;
  logic           overflow_q, overflow_d;
  logic           size_err_q, size_err_d;

  logic           fval_rise, fval_fall, lval_fall;
  logic           sample, pop, push_req, overflow_evt, size_evt;
  logic           fifo_full, fifo_empty, head_valid;
  logic [EW-1:0]  fifo_rd_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (pix_clk),
    .rst     (rstb),
    .wr_en   (push_req),
    .wr_data (stg_entry_q),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Sampled pixels wait one cycle in a staging register before the FIFO push.
  always_comb begin
    fval_rise    = fval && !fval_q;
    fval_fall    = !fval && fval_q;
    lval_fall    = !lval && lval_q;
    sample       = (state_q == IN_FRAME) && fval && lval && dval;
    pop          = m_tvalid && m_tready;
    push_req     = stg_valid_q && (state_q != DROP_FRAME);
    overflow_evt = push_req && fifo_full && !pop;

    stg_valid_d = sample;
    stg_entry_d = stg_entry_q;
    if (sample) begin
      stg_entry_d[DATA_WIDTH-1:0] = pix_data;
      stg_entry_d[EOL_BIT]        = (pix_cnt_q == PIX_LAST);
      stg_entry_d[SOF_BIT]        = sof_pend_q;
    end

    sof_pend_d = sof_pend_q;
    if ((state_q == WAIT_FRAME) && fval_rise) sof_pend_d = 1'b1;
    else if (sample)                          sof_pend_d = 1'b0;

    pix_cnt_d = pix_cnt_q;
    if (lval_fall || fval_rise)           pix_cnt_d = '0;
    else if (sample && pix_cnt_q != '1)   pix_cnt_d = pix_cnt_q + PW'(1);

    lines_done = line_cnt_q;
    if (lval_fall && line_cnt_q != '1) lines_done = line_cnt_q + LW'(1);
    line_cnt_d = fval_rise ? '0 : lines_done;

    size_evt = (state_q == IN_FRAME) &&
               ((lval_fall && pix_cnt_q != PIX_FULL) ||
                (fval_fall && lines_done != LINE_FULL));

    overflow_d = overflow_evt ? 1'b1 : (clr_err ? 1'b0 : overflow_q);
    size_err_d = size_evt     ? 1'b1 : (clr_err ? 1'b0 : size_err_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_FRAME: if (fval_rise) state_d = IN_FRAME;
      IN_FRAME: begin
        if (fval_fall)         state_d = WAIT_FRAME;
        else if (overflow_evt) state_d = DROP_FRAME;
      end
      DROP_FRAME: if (fval_fall) state_d = WAIT_FRAME;
      default:    state_d = WAIT_FRAME;
    endcase
  end

  // fval history resets high so a reset released mid-frame is not a frame start.
  always_ff @(posedge pix_clk or posedge rstb) begin
    if (rstb) begin
      state_q     <= WAIT_FRAME;
      fval_q      <= 1'b1;
      lval_q      <= 1'b0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      sof_pend_q  <= 1'b0;
      stg_valid_q <= 1'b0;
      stg_entry_q <= '0;
      overflow_q  <= 1'b0;
      size_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fval_q      <= fval;
      lval_q      <= lval;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      sof_pend_q  <= sof_pend_d;
      stg_valid_q <= stg_valid_d;
      stg_entry_q <= stg_entry_d;
      overflow_q  <= overflow_d;
      size_err_q  <= size_err_d;
    end
  end

  assign head_valid = (fifo_count != '0);
  assign m_tvalid   = !fifo_empty;
  assign m_tdata    = head_valid ? fifo_rd_data[DATA_WIDTH-1:0] : '0;
  assign m_tuser    = head_valid && fifo_rd_data[SOF_BIT];
  assign m_tlast    = head_valid && fifo_rd_data[EOL_BIT];
  assign overflow   = overflow_q;
  assign size_err   = size_err_q;

endmodule

// File: doc/video_axis_bridge.md
VIDEO_AXIS_BRIDGE -- requirements
Module: video_axis_bridge

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 24, setting the pixel word width (3x8 colored overlay output).
REQ-002 The block SHALL have parameter FRAME_W, default 640, setting the expected pixels per line.
REQ-003 The block SHALL have parameter FRAME_H, default 480, setting the expected lines per frame.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 16, a power of 2 and at least 4, setting the buffer entries.
REQ-005 The block SHALL have port pix_clk, input, 1 bit: the single clock; the block has one clock, and its reset is asynchronous and active-high.
REQ-006 The block SHALL have port rstb, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have ports fval, lval and dval, inputs, 1 bit each: frame, line and data valid from the overlay stage.
REQ-008 The block SHALL have port pix_data, input, DATA_WIDTH bits: the overlaid pixel.
REQ-009 The block SHALL have port m_tdata, output, DATA_WIDTH bits: the stream pixel.
REQ-010 The block SHALL have ports m_tvalid (output), m_tready (input), m_tuser (output, start of frame) and m_tlast (output, end of line), 1 bit each.
REQ-011 The block SHALL have ports overflow and size_err, outputs, 1 bit each: sticky error flags.
REQ-012 The block SHALL have port clr_err, input, 1 bit: synchronous clear of both sticky flags.

Function
REQ-013 A pixel SHALL be sampled on a pix_clk edge where fval, lval and dval are all 1 and the state is IN_FRAME.
REQ-014 The FSM SHALL use states WAIT_FRAME, IN_FRAME and DROP_FRAME; from reset it enters WAIT_FRAME.
REQ-015 WAIT_FRAME SHALL go to IN_FRAME only on a rising fval edge (fval was 0 on the previous cycle), so a reset released mid-frame skips that frame.
REQ-016 IN_FRAME SHALL go to WAIT_FRAME on falling fval, and to DROP_FRAME on overflow.
REQ-017 DROP_FRAME SHALL discard all pixels and go to WAIT_FRAME on falling fval.
REQ-018 Each FIFO entry SHALL hold {sof, eol, pixel}; sof=1 for the first sampled pixel of a frame; eol=1 when the in-line pixel count equals FRAME_W-1.
REQ-019 The pixel counter SHALL reset on falling lval; the line counter SHALL increment on falling lval and reset on rising fval.
REQ-020 Falling lval with pixel count != FRAME_W, or falling fval with line count != FRAME_H, SHALL set size_err; the data path continues.
REQ-021 m_tvalid SHALL be 1 when the FIFO is non-empty; the head entry is popped on an edge where m_tvalid and m_tready are both 1.
REQ-022 m_tdata, m_tuser and m_tlast SHALL be the head entry fields and SHALL stay stable while m_tvalid=1 and m_tready=0.
REQ-023 Latency SHALL be one cycle: a pixel sampled into an empty FIFO at edge N shows m_tvalid=1 after edge N+1.
REQ-024 A push to a full FIFO SHALL be accepted if a pop occurs on the same edge; otherwise the pixel is lost, overflow is set and the FSM goes to DROP_FRAME.
REQ-025 Push and pop on the same edge SHALL leave the count unchanged, and the read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 If clr_err and an error event fall on the same edge, the error event SHALL win and the flag stays 1.

Reset
REQ-027 While rstb=1, the block SHALL hold: state WAIT_FRAME, FIFO empty, m_tvalid=0, m_tuser=0, m_tlast=0, m_tdata=0, overflow=0, size_err=0, all counters 0.
REQ-028 A reset asserted mid-frame SHALL discard the FIFO contents immediately, and output restarts at the next full frame.

Structure
REQ-029 The shared package osd_defs SHALL hold the FSM state encoding, the FIFO entry field offsets and the counter width functions ($clog2(FRAME_W)+1, $clog2(FRAME_H)+1).
REQ-030 The FIFO SHALL be the sub-module sync_fifo (width DATA_WIDTH+2, depth FIFO_DEPTH, with full/empty/count); the FSM, counters and flags stay in video_axis_bridge.

Verification (bench FRAME_W=4, FRAME_H=2, FIFO_DEPTH=4)
REQ-031 One frame of pixels 1..8, m_tready=1 -> 8 beats; tuser on beat 1 only; tlast on beats 4 and 8; no flags set.
REQ-032 The same frame with m_tready=0 for 6 cycles from the first beat -> FIFO fills at 4; pixel 5 lost; overflow=1; after m_tready=1 only pixels 1..4 come out; the next frame passes intact.
REQ-033 A line of 3 pixels then falling lval -> size_err=1; clr_err pulse -> 0; clr_err on the same edge as a new short line -> stays 1.
REQ-034 Reset released while fval=1 mid-frame -> no beats until the next rising fval; the next frame arrives complete with tuser on its first pixel.
REQ-035 dval toggling 1,0,1,0 within lines and m_tready toggling randomly -> all 8 pixels in order, with m_tdata held stable while stalled.
REQ-036 rstb pulse with 3 entries buffered -> m_tvalid=0 on the next cycle and overflow=size_err=0.
